// File: rtl/suffix_dfa_pkg.sv
// Shared types and constants for the programmable serial suffix detector.
// Config struct is sized for the largest supported pattern; instances use the low bits.
package suffix_dfa_pkg;

  localparam int unsigned PAT_CAP   = 64;
  localparam int unsigned LEN_CAP_W = 8;

  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  typedef struct packed {
    logic [PAT_CAP-1:0]   pattern;
    logic [LEN_CAP_W-1:0] len;
    logic                 overlap;
  } cfg_t;

  localparam logic [PAT_CAP-1:0]   RST_PATTERN = '0;
  localparam logic [LEN_CAP_W-1:0] RST_LEN     = 8'd1;
  localparam logic                 RST_OVERLAP = 1'b1;

endpackage

// File: rtl/suffix_dfa_if.sv
// Serial data, configuration and match-status bundle of suffix_dfa.
interface suffix_dfa_if
  import suffix_dfa_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 16
);

  localparam int unsigned LEN_W = len_w(MAX_LEN);

  logic               in;
  logic               in_valid;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               accept;
  logic               match_pulse;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output in, in_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap,
    input  accept, match_pulse, match_count
  );

  modport slave (
    input  in, in_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap,
    output accept, match_pulse, match_count
  );

endinterface

// File: rtl/sat_counter.sv
// Synchronous-clear up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/suffix_dfa.sv
// Runtime-programmable suffix acceptor: flags when the newest len accepted bits
// equal the stored pattern, with overlap control and a saturating match count.
module suffix_dfa
  import suffix_dfa_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  suffix_dfa_if.slave bus
);

  localparam int unsigned LEN_W = len_w(MAX_LEN);

  cfg_t               cfg_q;
  cfg_t               cfg_d;
  logic [MAX_LEN-1:0] hist_q;
  logic [MAX_LEN-1:0] hist_d;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   fill_d;
  logic [MAX_LEN-1:0] mask;
  logic               hit;
  logic               consume;
  logic               accept_q;
  logic               pulse_q;
  logic [CNT_W-1:0]   count;

  // Length is clamped to 1..MAX_LEN at load time so the comparator never sees 0.
  always_comb begin
    cfg_d = '0;
    cfg_d.pattern[MAX_LEN-1:0] = bus.cfg_pattern;
    cfg_d.overlap = bus.cfg_overlap;
    if (bus.cfg_len == '0) begin
      cfg_d.len = 8'd1;
    end else if (32'(bus.cfg_len) > MAX_LEN) begin
      cfg_d.len = LEN_CAP_W'(MAX_LEN);
    end else begin
      cfg_d.len = LEN_CAP_W'(bus.cfg_len);
    end
  end

  always_comb begin
    hist_d = {hist_q[MAX_LEN-2:0], bus.in};
    fill_d = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    mask   = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < 32'(cfg_q.len));
    end
    hit = (32'(fill_d) >= 32'(cfg_q.len)) &&
          (((hist_d ^ cfg_q.pattern[MAX_LEN-1:0]) & mask) == '0);
  end

  assign consume = bus.in_valid & ~bus.cfg_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q    <= '{pattern: RST_PATTERN, len: RST_LEN, overlap: RST_OVERLAP};
      hist_q   <= '0;
      fill_q   <= '0;
      accept_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else if (bus.cfg_we) begin
      cfg_q    <= cfg_d;
      hist_q   <= '0;
      fill_q   <= '0;
      accept_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else if (bus.in_valid) begin
      hist_q   <= hist_d;
      // Non-overlap mode forgets the matched bits so the next hit needs len fresh ones.
      fill_q   <= (hit && !cfg_q.overlap) ? '0 : fill_d;
      accept_q <= hit;
      pulse_q  <= hit;
    end else begin
      pulse_q  <= 1'b0;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.cfg_we),
    .inc  (consume & hit),
    .count(count)
  );

  assign bus.accept      = accept_q;
  assign bus.match_pulse = pulse_q;
  assign bus.match_count = count;

  logic unused_hist_msb;
  assign unused_hist_msb = hist_q[MAX_LEN-1];

  if (MAX_LEN < PAT_CAP) begin : g_pat_pad
    logic unused_pat_hi;
    assign unused_pat_hi = ^cfg_q.pattern[PAT_CAP-1:MAX_LEN];
  end

endmodule

// File: tb/tb_suffix_dfa.sv
// Directed bench for suffix_dfa; a second instance with a 2-bit counter shares the stimulus.
module tb_suffix_dfa;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  suffix_dfa_if #(.MAX_LEN(8), .CNT_W(16)) bus ();
  suffix_dfa_if #(.MAX_LEN(8), .CNT_W(2))  bus2 ();

  assign bus2.in          = bus.in;
  assign bus2.in_valid    = bus.in_valid;
  assign bus2.cfg_we      = bus.cfg_we;
  assign bus2.cfg_pattern = bus.cfg_pattern;
  assign bus2.cfg_len     = bus.cfg_len;
  assign bus2.cfg_overlap = bus.cfg_overlap;

  suffix_dfa #(.MAX_LEN(8), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  suffix_dfa #(.MAX_LEN(8), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic ea, input logic ep, input int unsigned ec);
    chk({tag, ".accept"}, 32'(bus.accept), 32'(ea));
    chk({tag, ".pulse"},  32'(bus.match_pulse), 32'(ep));
    chk({tag, ".count"},  32'(bus.match_count), ec);
  endtask

  task automatic send(input string tag, input logic b, input logic ea, input logic ep,
                      input int unsigned ec);
    bus.in       = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    outs(tag, ea, ep, ec);
  endtask

  task automatic hold(input string tag, input int unsigned n, input logic ea, input int unsigned ec);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
      outs(tag, ea, 1'b0, ec);
    end
  endtask

  task automatic configure(input string tag, input logic [7:0] pat, input logic [3:0] len,
                           input logic ov);
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ov;
    bus.cfg_we      = 1'b1;
    @(posedge clk); #1;
    bus.cfg_we      = 1'b0;
    outs(tag, 1'b0, 1'b0, 0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.in          = 1'b0;
    bus.in_valid    = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_overlap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    outs("reset", 1'b0, 1'b0, 0);
    rst = 1'b0;

    // Default: ends with 0
    send("def1", 1'b1, 1'b0, 1'b0, 0);
    send("def2", 1'b1, 1'b0, 1'b0, 0);
    send("def3", 1'b0, 1'b1, 1'b1, 1);
    send("def4", 1'b0, 1'b1, 1'b1, 2);
    send("def5", 1'b1, 1'b0, 1'b0, 2);
    send("def6", 1'b0, 1'b1, 1'b1, 3);
    send("def7", 1'b1, 1'b0, 1'b0, 3);
    send("def8", 1'b1, 1'b0, 1'b0, 3);

    // 1101 overlapping, stream 1101101
    configure("cfg_ov", 8'b1101, 4'd4, 1'b1);
    send("ov1", 1'b1, 1'b0, 1'b0, 0);
    send("ov2", 1'b1, 1'b0, 1'b0, 0);
    send("ov3", 1'b0, 1'b0, 1'b0, 0);
    send("ov4", 1'b1, 1'b1, 1'b1, 1);
    send("ov5", 1'b1, 1'b0, 1'b0, 1);
    send("ov6", 1'b0, 1'b0, 1'b0, 1);
    send("ov7", 1'b1, 1'b1, 1'b1, 2);

    // 1101 non-overlapping, stream 1101101 then 1101
    configure("cfg_nov", 8'b1101, 4'd4, 1'b0);
    send("nov1", 1'b1, 1'b0, 1'b0, 0);
    send("nov2", 1'b1, 1'b0, 1'b0, 0);
    send("nov3", 1'b0, 1'b0, 1'b0, 0);
    send("nov4", 1'b1, 1'b1, 1'b1, 1);
    send("nov5", 1'b1, 1'b0, 1'b0, 1);
    send("nov6", 1'b0, 1'b0, 1'b0, 1);
    send("nov7", 1'b1, 1'b0, 1'b0, 1);
    send("nov8", 1'b1, 1'b0, 1'b0, 1);
    send("nov9", 1'b1, 1'b0, 1'b0, 1);
    send("nov10", 1'b0, 1'b0, 1'b0, 1);
    send("nov11", 1'b1, 1'b1, 1'b1, 2);

    // 101 with idle gaps
    configure("cfg_gap", 8'b101, 4'd3, 1'b1);
    send("gap1", 1'b1, 1'b0, 1'b0, 0);
    hold("gap1h", 3, 1'b0, 0);
    send("gap2", 1'b0, 1'b0, 1'b0, 0);
    hold("gap2h", 3, 1'b0, 0);
    send("gap3", 1'b1, 1'b1, 1'b1, 1);
    hold("gap3h", 3, 1'b1, 1);
    send("gap4", 1'b0, 1'b0, 1'b0, 1);
    send("gap5", 1'b1, 1'b1, 1'b1, 2);

    // Saturation on the 2-bit counter instance
    configure("cfg_sat", 8'b1, 4'd1, 1'b1);
    chk("sat0.count2", 32'(bus2.match_count), 0);
    for (int unsigned i = 1; i <= 6; i++) begin
      send("sat", 1'b1, 1'b1, 1'b1, i);
      chk("sat.count2",  32'(bus2.match_count), (i > 3) ? 3 : i);
      chk("sat.accept2", 32'(bus2.accept), 1);
    end

    // len 0 behaves as len 1; pattern bit2 must be ignored
    configure("cfg_len0", 8'b101, 4'd0, 1'b1);
    send("len0a", 1'b0, 1'b0, 1'b0, 0);
    send("len0b", 1'b1, 1'b1, 1'b1, 1);

    // len 15 clamps to 8: a 7-bit suffix match alone must not hit
    configure("cfg_len15a", 8'hA5, 4'd15, 1'b1);
    send("l15a1", 1'b0, 1'b0, 1'b0, 0);
    send("l15a2", 1'b0, 1'b0, 1'b0, 0);
    send("l15a3", 1'b1, 1'b0, 1'b0, 0);
    send("l15a4", 1'b0, 1'b0, 1'b0, 0);
    send("l15a5", 1'b0, 1'b0, 1'b0, 0);
    send("l15a6", 1'b1, 1'b0, 1'b0, 0);
    send("l15a7", 1'b0, 1'b0, 1'b0, 0);
    send("l15a8", 1'b1, 1'b0, 1'b0, 0);
    configure("cfg_len15b", 8'hA5, 4'd15, 1'b1);
    send("l15b1", 1'b1, 1'b0, 1'b0, 0);
    send("l15b2", 1'b0, 1'b0, 1'b0, 0);
    send("l15b3", 1'b1, 1'b0, 1'b0, 0);
    send("l15b4", 1'b0, 1'b0, 1'b0, 0);
    send("l15b5", 1'b0, 1'b0, 1'b0, 0);
    send("l15b6", 1'b1, 1'b0, 1'b0, 0);
    send("l15b7", 1'b0, 1'b0, 1'b0, 0);
    send("l15b8", 1'b1, 1'b1, 1'b1, 1);

    // cfg_we with in_valid mid-match: bit dropped, state cleared
    configure("cfg_11", 8'b11, 4'd2, 1'b1);
    send("cw1", 1'b1, 1'b0, 1'b0, 0);
    send("cw2", 1'b1, 1'b1, 1'b1, 1);
    bus.in       = 1'b1;
    bus.in_valid = 1'b1;
    bus.cfg_we   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    outs("cw_drop", 1'b0, 1'b0, 0);
    send("cw3", 1'b1, 1'b0, 1'b0, 0);

    // Reset mid-stream restores "ends with 0" and drops history
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    outs("rst_mid", 1'b0, 1'b0, 0);
    send("rm1", 1'b1, 1'b0, 1'b0, 0);
    send("rm2", 1'b0, 1'b1, 1'b1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/suffix_dfa.md
Name: suffix_dfa

Overview:
- Parametrised serial suffix-recognising DFA; generalises the fixed "ends with 0" acceptor to a runtime-programmable bit pattern of up to MAX_LEN bits.
- Consumes one qualified bit per cycle and holds `accept` while the most recent bits equal the pattern.
- Adds overlap/non-overlap mode, a per-match pulse and a saturating match counter.
- Sits in the fsm/dfa library as the reusable serial pattern detector.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 16, width of the match counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  1  serial data bit.
- in_valid  input  1  `in` is consumed this cycle when high.
- cfg_we  input  1  load configuration this cycle.
- cfg_pattern  input  MAX_LEN  pattern; bit[len-1] is the oldest bit, bit[0] the newest.
- cfg_len  input  $clog2(MAX_LEN+1)  pattern length.
- cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- accept  output  1  DFA is in an accepting state.
- match_pulse  output  1  one-cycle strobe on each match.
- match_count  output  CNT_W  saturating count of matches.

Behaviour:
- Reset state:
  - pattern=0, len=1, overlap=1, so out of reset the block is functionally "ends with 0".
  - hist=0, fill=0, accept=0, match_pulse=0, match_count=0.
- Internal state:
  - hist[MAX_LEN-1:0] holds the accepted bits, newest at bit 0.
  - fill (0..MAX_LEN) counts valid history bits since the last clear, saturating at MAX_LEN.
- Config legalisation: len is stored clamped to 1..MAX_LEN (cfg_len=0 gives 1; cfg_len>MAX_LEN gives MAX_LEN). Pattern bits above len are ignored.
- On a consumed bit (in_valid=1, cfg_we=0, rst=0):
  - next hist = {hist[MAX_LEN-2:0], in}; next fill = min(fill+1, MAX_LEN).
  - hit = (next fill >= len) and (next hist[len-1:0] == pattern[len-1:0]).
  - accept <= hit and match_pulse <= hit, both registered, so visible the cycle after the bit is sampled (latency 1).
  - On hit, match_count increments, saturating at 2^CNT_W-1 (no wrap).
  - On hit with overlap=0, fill is cleared to 0 after the shift, so the next match needs len fresh bits. accept still reports 1 for this hit.
- No consumed bit (in_valid=0):
  - hist, fill and accept hold.
  - match_pulse=0, so a pulse lasts exactly one cycle even when the next bit is delayed.
- cfg_we=1:
  - Loads pattern/len/overlap.
  - Clears hist, fill, accept, match_pulse and match_count the next cycle.
  - A simultaneous in_valid bit is discarded (config wins).
- rst has priority over cfg_we and in_valid.
- Reset mid-stream discards partial history; there is no carry-over across reset or reconfiguration.
- accept and match_pulse are identical on the cycle after a hit. accept may then remain high; match_pulse may not.

Decomposition:
- Package suffix_dfa_pkg holds:
  - the LEN_W = $clog2(MAX_LEN+1) width function;
  - reset constants RST_PATTERN=0, RST_LEN=1, RST_OVERLAP=1;
  - a config struct {pattern, len, overlap}.
- Sub-module sat_counter (parameter W; ports clk, rst, clr, inc, count) implements the saturating match counter.
- The comparator and history register stay in suffix_dfa.

Test Plan:
- Defaults after reset, stream 1,1,0,0 → accept 0,0,1,1; match_pulse on bits 3 and 4; count=2. Then 1,0,1,1 → accept 0,1,0,0.
- Pattern 1101, len 4, overlap=1, stream 1101101 → pulses after bits 4 and 7; accept=1 after bit 7; count=2.
- Same pattern with overlap=0:
  - Stream 1101101 → single pulse at bit 4; count=1.
  - Then stream 1101 → pulse; count=2.
- Pattern 101, in_valid gaps of 3 idle cycles between bits:
  - accept holds across the gaps.
  - match_pulse is exactly 1 cycle wide.
- CNT_W=2, pattern 1, len 1, stream of 6 ones → count 1,2,3,3,3,3; accept stays 1.
- Config edge cases:
  - cfg_we with cfg_len=0 and pattern bit0=1 behaves as len 1.
  - cfg_len=15 with MAX_LEN=8 clamps to 8.
  - cfg_we asserted together with in_valid mid-match → bit dropped; accept, match_pulse and count read 0 next cycle.
